// File: rtl/cpu_result_checker_if.sv
// Bus between the result checker and whoever drives it: table load port,
// run control, the CPU result stream and the verdict outputs.
interface cpu_result_checker_if #(
   parameter int ERR_W = 8
);
   logic             ld_en;
   logic [7:0]       ld_addr;
   logic [33:0]      ld_data;
   logic             start;
   logic             res_valid;
   logic [31:0]      alu_f;
   logic             zf;
   logic             of;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_cnt;
   logic [7:0]       first_err;
   logic             err_seen;

   modport master (
      output ld_en, ld_addr, ld_data, start, res_valid, alu_f, zf, of,
      input  busy, done, pass, err_cnt, first_err, err_seen
   );

   modport slave (
      input  ld_en, ld_addr, ld_data, start, res_valid, alu_f, zf, of,
      output busy, done, pass, err_cnt, first_err, err_seen
   );
endinterface

// File: rtl/cpu_result_checker.sv
// Compares each retired CPU result {OF, ZF, ALU_F} against a preloaded
// expected-value table, counts mismatches (saturating) and latches the
// index of the first failing result. Produces a pass/fail verdict in DONE.
module cpu_result_checker #(
   parameter int N_CHECK = 16,
   parameter int ERR_W   = 8
) (
   input logic           clk,
   input logic           rst,
   cpu_result_checker_if.slave bus
);
   localparam int         IW   = (N_CHECK > 1) ? $clog2(N_CHECK) : 1;
   localparam logic [7:0] LAST = 8'(N_CHECK - 1);
   localparam logic [8:0] NCHK = 9'(N_CHECK);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [7:0]       idx_q, idx_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic [7:0]       first_err_q, first_err_d;
   logic             err_seen_q, err_seen_d;

   // expected-value storage; deliberately not reset so it survives runs
   logic [33:0]      tbl_q [N_CHECK];
   logic             tbl_we_d;
   logic [IW-1:0]    tbl_wa_d;
   logic [33:0]      tbl_wd_d;
   logic [33:0]      exp_val;
   logic [33:0]      act_val;
   logic             mismatch;

   // table write decode: only in IDLE, out-of-range addresses dropped
   always_comb begin
      tbl_we_d = (state_q == IDLE) && bus.ld_en && ({1'b0, bus.ld_addr} < NCHK);
      tbl_wa_d = bus.ld_addr[IW-1:0];
      tbl_wd_d = bus.ld_data;
   end

   // table write port (no reset on purpose)
   always_ff @(posedge clk) begin
      if (tbl_we_d) tbl_q[tbl_wa_d] <= tbl_wd_d;
   end

   assign exp_val  = tbl_q[idx_q[IW-1:0]];
   assign act_val  = {bus.of, bus.zf, bus.alu_f};
   assign mismatch = (act_val != exp_val);

   // next-state: run control, compare bookkeeping, saturating error count
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      err_cnt_d   = err_cnt_q;
      first_err_d = first_err_q;
      err_seen_d  = err_seen_q;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d     = RUN;
               idx_d       = '0;
               err_cnt_d   = '0;
               first_err_d = '0;
               err_seen_d  = 1'b0;
            end
         end
         RUN: begin
            if (bus.res_valid) begin
               if (mismatch) begin
                  if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
                  if (!err_seen_q) begin
                     first_err_d = idx_q;
                     err_seen_d  = 1'b1;
                  end
               end
               idx_d = idx_q + 8'd1;
               if (idx_q == LAST) state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state registers, asynchronously cleared
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         err_cnt_q   <= '0;
         first_err_q <= '0;
         err_seen_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         err_cnt_q   <= err_cnt_d;
         first_err_q <= first_err_d;
         err_seen_q  <= err_seen_d;
      end
   end

   assign bus.busy      = (state_q == RUN);
   assign bus.done      = (state_q == DONE);
   assign bus.pass      = (state_q == DONE) && (err_cnt_q == '0);
   assign bus.err_cnt   = err_cnt_q;
   assign bus.first_err = first_err_q;
   assign bus.err_seen  = err_seen_q;
endmodule

// File: tb/tb_cpu_result_checker.sv
// Scoreboard bench: stimulus pushes the expected verdict state for each
// consumed result; monitors pop and compare whenever a DUT consumes one.
module tb_cpu_result_checker;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cpu_result_checker_if #(.ERR_W(8)) mif ();
   cpu_result_checker_if #(.ERR_W(2)) sif ();

   cpu_result_checker #(.N_CHECK(16), .ERR_W(8)) dut (
      .clk(clk), .rst(rst), .bus(mif.slave));
   cpu_result_checker #(.N_CHECK(8), .ERR_W(2)) dut_s (
      .clk(clk), .rst(rst), .bus(sif.slave));

   typedef struct {int ec; bit seen; int first; bit done;} exp_t;
   exp_t q0[$];
   exp_t q1[$];
   int checks = 0;
   int failures = 0;

   // reference model: expected table plus a run in terms of position/mismatch count
   logic [33:0] exp_tbl [16];
   bit m_run, m_idle;
   int m_pos, m_mis, m_first;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic m_reset();
      m_run = 0; m_idle = 1; m_pos = 0; m_mis = 0; m_first = 0;
   endtask

   // one cycle on the main DUT; starts and ends at a falling edge
   task automatic cyc(input bit v, input logic [33:0] val, input bit st,
                      input bit ld, input logic [7:0] la, input logic [33:0] ldd);
      exp_t e;
      mif.res_valid = v;
      {mif.of, mif.zf, mif.alu_f} = val;
      mif.start = st; mif.ld_en = ld; mif.ld_addr = la; mif.ld_data = ldd;
      if (m_run) begin
         if (v) begin
            if (val !== exp_tbl[m_pos]) begin
               if (m_mis == 0) m_first = m_pos;
               m_mis++;
            end
            e.ec = (m_mis > 255) ? 255 : m_mis;
            e.seen = (m_mis > 0);
            e.first = m_first;
            e.done = (m_pos == 15);
            q0.push_back(e);
            if (m_pos == 15) m_run = 0;
            else m_pos++;
         end
      end else begin
         if (m_idle && ld && la < 16) exp_tbl[la] = ldd;
         if (st) begin
            m_run = 1; m_idle = 0; m_pos = 0; m_mis = 0; m_first = 0;
         end
      end
      @(negedge clk);
      mif.res_valid = 0; mif.start = 0; mif.ld_en = 0;
   endtask

   task automatic res(input logic [33:0] v);  cyc(1, v, 0, 0, 8'd0, 34'd0); endtask
   task automatic go();                       cyc(0, 34'd0, 1, 0, 8'd0, 34'd0); endtask
   task automatic load(input logic [7:0] a, input logic [33:0] d); cyc(0, 34'd0, 0, 1, a, d); endtask

   function automatic logic [33:0] plan_val(input int i);
      return {1'b0, (i == 0), 32'(i * 3)};
   endfunction

   function automatic logic [33:0] flip(input logic [33:0] v, input int b);
      logic [33:0] one;
      one = 34'd1;
      return v ^ (one << b);
   endfunction

   task automatic chk_reset_out(input string tag);
      chk({tag, "_busy"}, mif.busy, 0);
      chk({tag, "_done"}, mif.done, 0);
      chk({tag, "_pass"}, mif.pass, 0);
      chk({tag, "_err_cnt"}, mif.err_cnt, 0);
      chk({tag, "_err_seen"}, mif.err_seen, 0);
      chk({tag, "_first_err"}, mif.first_err, 0);
   endtask

   // monitor for the main DUT
   bit c0;
   exp_t e0;
   always @(posedge clk) begin
      c0 = mif.busy && mif.res_valid;
      #1;
      if (c0) begin
         if (q0.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_unexpected actual=consumed required=no_result_pending");
         end else begin
            e0 = q0.pop_front();
            chk("err_cnt", mif.err_cnt, e0.ec);
            chk("err_seen", mif.err_seen, e0.seen);
            chk("first_err", mif.first_err, e0.first);
            chk("done", mif.done, e0.done);
            chk("pass", mif.pass, e0.done && e0.ec == 0);
            chk("busy", mif.busy, !e0.done);
         end
      end
   end

   // monitor for the small saturating DUT
   bit c1;
   exp_t e1;
   always @(posedge clk) begin
      c1 = sif.busy && sif.res_valid;
      #1;
      if (c1) begin
         if (q1.size() == 0) begin
            checks++; failures++;
            $display("FAIL sat_sb_unexpected actual=consumed required=no_result_pending");
         end else begin
            e1 = q1.pop_front();
            chk("sat_err_cnt", sif.err_cnt, e1.ec);
            chk("sat_err_seen", sif.err_seen, e1.seen);
            chk("sat_first_err", sif.first_err, e1.first);
            chk("sat_done", sif.done, e1.done);
         end
      end
   end

   initial begin
      logic [33:0] tbl_s [8];
      logic [33:0] v;
      exp_t e;
      mif.ld_en = 0; mif.ld_addr = 0; mif.ld_data = 0; mif.start = 0;
      mif.res_valid = 0; mif.alu_f = 0; mif.zf = 0; mif.of = 0;
      sif.ld_en = 0; sif.ld_addr = 0; sif.ld_data = 0; sif.start = 0;
      sif.res_valid = 0; sif.alu_f = 0; sif.zf = 0; sif.of = 0;
      m_reset();
      repeat (2) @(negedge clk);
      chk_reset_out("reset");
      rst = 1;
      @(negedge clk);

      // clean run; out-of-range writes must not alias entry 0, last load shares a cycle with start
      for (int i = 0; i < 15; i++) load(8'(i), plan_val(i));
      load(8'd16, 34'h3_FFFF_FFFF);
      load(8'd32, 34'h2_1234_5678);
      cyc(0, 34'd0, 1, 1, 8'd15, plan_val(15));
      for (int i = 0; i < 16; i++) res(exp_tbl[i]);
      chk("clean_done", mif.done, 1);
      chk("clean_pass", mif.pass, 1);

      // single ALU mismatch at index 5
      go();
      for (int i = 0; i < 16; i++) res(i == 5 ? {exp_tbl[i][33:32], 32'hDEADBEEF} : exp_tbl[i]);
      chk("single_first_err", mif.first_err, 5);
      chk("single_pass", mif.pass, 0);

      // flag-only mismatches: OF at 3, ZF at 9
      go();
      for (int i = 0; i < 16; i++)
         res(i == 3 ? flip(exp_tbl[i], 33) : i == 9 ? flip(exp_tbl[i], 32) : exp_tbl[i]);
      chk("flags_err_cnt", mif.err_cnt, 2);
      chk("flags_first_err", mif.first_err, 3);

      // reset in the middle of a run, then the retained table still passes
      go();
      for (int i = 0; i < 4; i++) res(flip(exp_tbl[i], 0));
      rst = 0;
      #1;
      chk_reset_out("midrun_rst");
      m_reset();
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      go();
      for (int i = 0; i < 16; i++) res(exp_tbl[i]);
      chk("after_rst_pass", mif.pass, 1);

      // ignored controls: load and start during RUN, results during DONE
      go();
      cyc(1, exp_tbl[0], 0, 1, 8'd2, 34'h1_5555_AAAA);
      cyc(1, exp_tbl[1], 1, 0, 8'd0, 34'd0);
      for (int i = 2; i < 16; i++) res(i == 5 ? flip(exp_tbl[i], 7) : exp_tbl[i]);
      for (int i = 0; i < 3; i++) res(34'h0_0BAD_0BAD);
      chk("done_ignore_err_cnt", mif.err_cnt, m_mis);
      chk("done_ignore_first", mif.first_err, 5);
      chk("done_hold", mif.done, 1);
      go();
      chk("restart_busy", mif.busy, 1);
      chk("restart_err_cnt", mif.err_cnt, 0);
      chk("restart_done", mif.done, 0);
      for (int i = 0; i < 16; i++) res(exp_tbl[i]);

      // randomized runs on a fresh random table
      rst = 0;
      m_reset();
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      for (int i = 0; i < 16; i++) load(8'(i), {2'($urandom_range(3, 0)), 32'($urandom())});
      for (int r = 0; r < 8; r++) begin
         go();
         for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(2, 0)) cyc(0, 34'($urandom()), $urandom_range(3, 0) == 0,
                                             $urandom_range(3, 0) == 0, 8'($urandom_range(15, 0)),
                                             34'($urandom()));
            v = exp_tbl[i];
            if ($urandom_range(3, 0) == 0) v = flip(v, $urandom_range(33, 0));
            res(v);
         end
         chk("rand_done", mif.done, 1);
         chk("rand_pass", mif.pass, m_mis == 0);
      end

      // saturation on the ERR_W=2, N_CHECK=8 instance
      for (int i = 0; i < 8; i++) begin
         tbl_s[i] = {2'($urandom_range(3, 0)), 32'($urandom())};
         sif.ld_en = 1; sif.ld_addr = 8'(i); sif.ld_data = tbl_s[i];
         @(negedge clk);
      end
      sif.ld_en = 0;
      sif.start = 1;
      @(negedge clk);
      sif.start = 0;
      for (int k = 0; k < 8; k++) begin
         sif.res_valid = 1;
         {sif.of, sif.zf, sif.alu_f} = flip(tbl_s[k], $urandom_range(33, 0));
         e.ec = (k + 1 > 3) ? 3 : k + 1;
         e.seen = 1; e.first = 0; e.done = (k == 7);
         q1.push_back(e);
         @(negedge clk);
      end
      sif.res_valid = 0;
      chk("sat_final_err_cnt", sif.err_cnt, 3);
      chk("sat_final_first", sif.first_err, 0);
      chk("sat_final_pass", sif.pass, 0);

      repeat (2) @(negedge clk);
      chk("sb_leftover", q0.size(), 0);
      chk("sat_sb_leftover", q1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cpu_result_checker.md
# cpu_result_checker

Self-checking result monitor that sits on the output side of the single-cycle CPU and consumes its per-instruction results (ALU_F, ZF, OF). It compares each retired result against an expected-value table preloaded through a write port, counts mismatches and records the first failing index. The stimulus side supplies clock and reset to the CPU; this block gives a synthesizable pass/fail verdict for bench and FPGA bring-up.

## Interface
- N_CHECK, 16: number of results compared per run, 1..256.
- ERR_W, 8: error-counter width; the counter saturates.

- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ld_en  in  1  table write strobe; honoured only in IDLE.
- ld_addr  in  8  table index; writes with ld_addr >= N_CHECK are dropped.
- ld_data  in  34  expected value, {OF, ZF, ALU_F[31:0]}.
- start  in  1  begin a run; honoured in IDLE and DONE.
- res_valid  in  1  one CPU result is presented this cycle.
- alu_f  in  32  CPU ALU_F.
- zf  in  1  CPU ZF.
- of  in  1  CPU OF.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  done and err_cnt == 0.
- err_cnt  out  ERR_W  mismatch count, saturating at all-ones.
- first_err  out  8  index of the first mismatch; valid when err_seen.
- err_seen  out  1  at least one mismatch this run.

## Operation
- Storage: N_CHECK x 34-bit register array with a combinational read at index idx. It is not cleared by reset. Contents persist across runs.
- FSM states and transitions:
  - IDLE -> RUN on start.
  - RUN -> DONE on the res_valid that consumes idx == N_CHECK-1.
  - DONE -> RUN on start.
  - No other transitions.
- Entering RUN clears idx, err_cnt, err_seen and first_err. done and pass drop in the same edge.
- In RUN, each res_valid cycle does the following:
  - Compare {of, zf, alu_f} with table[idx], all 34 bits.
  - On a mismatch, err_cnt increments unless it is saturated. If err_seen is 0, first_err <= idx and err_seen <= 1.
  - idx increments.
- res_valid is ignored in IDLE and DONE.
- start during RUN is ignored; the run is not restarted.
- ld_en outside IDLE is ignored. Tables are reloaded only after reset.
- Simultaneous ld_en and start in IDLE: the write commits, then RUN begins. The write is visible from the first RUN cycle.

## Timing
- Reset (asynchronous assertion, synchronous-safe release) sets:
  - state = IDLE, idx = 0
  - busy = 0, done = 0, pass = 0
  - err_cnt = 0, first_err = 0, err_seen = 0
- Reset mid-run aborts the run. No verdict is produced.
- Compare latency: the result is presented in cycle t, and err_cnt, err_seen and first_err reflect it after edge t+1.
- done and pass rise at the edge that consumes the last result, i.e. one cycle after that res_valid is sampled. Both hold until the next start or reset.
- Back-to-back res_valid every cycle is supported, with no stall.
- idx width is 8 bits. idx never wraps because the run ends at N_CHECK-1.
- With N_CHECK = 1, a single res_valid moves RUN -> DONE.

## Test plan
1. **Clean run.**
   - Stimulus: load table[i] = {0, (i==0), i*3} for i = 0..15, start, then drive the 16 matching results on consecutive cycles.
   - Required: done = 1 and pass = 1 one cycle after the last result; err_cnt = 0; err_seen = 0.
2. **Single mismatch.**
   - Stimulus: same table; index 5 driven with alu_f = 0xDEADBEEF.
   - Required: err_cnt = 1, first_err = 5, err_seen = 1, pass = 0.
3. **Flag-only mismatch and first-error latch.**
   - Stimulus: index 3 has OF flipped; index 9 has ZF flipped.
   - Required: err_cnt = 2, first_err = 3.
4. **Saturation.**
   - Stimulus: ERR_W = 2, N_CHECK = 8, all 8 results wrong.
   - Required: err_cnt = 3 (stays saturated), first_err = 0.
5. **Reset mid-run.**
   - Stimulus: assert rst low after 4 results.
   - Required: busy = 0, done = 0, err_cnt = 0 immediately, without waiting for a clock edge. A subsequent start plus 16 correct results gives pass = 1, since the table is retained.
6. **Ignored controls.**
   - Stimulus: ld_en to index 2 during RUN; start during RUN; res_valid during DONE.
   - Required: the table is unchanged, idx is not reset, and err_cnt is unchanged after DONE. A start in DONE begins a new run with err_cnt = 0.
